lcd_frame_writer: RTL and testbench
===================================

// Module: lcd_frame_writer
// PURPOSE
//  Downstream of the CGRAM pattern loader. Owns the 4-bit HD44780 bus once init_end rises.
//  Before that, it passes the loader's rs/rw/e/data straight through to the pins.
//  On each frame request it writes 32 character codes (2 rows x 16) from the game frame buffer into DDRAM.
//  Codes 0x00-0x06 select the custom glyphs (bar pieces, blank, character).
// PARAMETERS
//  SETUP_CYC   2  cycles rs/data stable with e=0 before e rises (>=1)
//  E_HIGH_CYC  4  cycles e held high per nibble (>=1)
//  HOLD_CYC    2  cycles e=0 after falling edge, data held (>=1)
//  GAP_CYC     8  idle cycles after each byte, e=0 (>=0)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous active-high reset
//  init_rs    in   1  loader rs
//  init_rw    in   1  loader rw
//  init_e     in   1  loader e
//  init_data  in   4  loader data nibble
//  init_end   in   1  loader finished; level
//  frame_req  in   1  request one full-frame write (sampled every cycle)
//  fb_addr    out  5  frame-buffer index: {row, col[3:0]}
//  fb_data    in   8  char code; valid 1 cycle after fb_addr is driven (registered RAM)
//  busy       out  1  frame write in progress
//  frame_done out  1  1-cycle pulse when the last byte's GAP completes
//  lcd_rs     out  1  LCD pin rs
//  lcd_rw     out  1  LCD pin rw
//  lcd_e      out  1  LCD pin e
//  lcd_data   out  4  LCD pin DB7..DB4
// BEHAVIOUR
//  Reset: state=WAIT_INIT, bus_sel=0, own rs=0, e=0, data=0, fb_addr=0, busy=0, frame_done=0, pending=0.
//  Pin mux: bus_sel=0 -> lcd_* = init_* (combinational); bus_sel=1 -> own registers.
//  lcd_rw is driven 0 whenever bus_sel=1.
//  bus_sel is a register: set the cycle after init_end is sampled 1; cleared when init_end is sampled 0.
//  FSM: WAIT_INIT -> IDLE -> CMD -> [FETCH -> CHAR]x16 -> CMD -> [FETCH -> CHAR]x16 -> DONE -> IDLE.
//   WAIT_INIT: hold until init_end=1, then go to IDLE.
//   IDLE: frame_req=1 or pending=1 -> accept; that is cycle 0. Clear pending; busy=1 from cycle 1.
//   CMD: send byte 0x80 (row 0) or 0xC0 (row 1) with rs=0.
//   FETCH: 2 cycles. Drive fb_addr in the first cycle, latch fb_data in the second.
//   CHAR: send the latched byte with rs=1.
//   DONE: frame_done=1 for 1 cycle and busy=0 in that same cycle. Return to IDLE.
//  Byte send: high nibble then low nibble.
//   Per nibble: SETUP_CYC cycles e=0, then E_HIGH_CYC cycles e=1, then HOLD_CYC cycles e=0.
//   rs/data are constant for the whole nibble window. After the low nibble: GAP_CYC cycles, e=0.
//  Defaults: 24 cycles/byte. Frame timing is 24+16*26+24+16*26 = 880 cycles; frame_done in cycle 881.
//  fb_addr sequence: 0..15, then 16..31. No wrap within a frame. fb_addr holds its last value when idle.
//  frame_req while busy: set pending (one-deep; extra requests merge).
//   The next frame starts in the cycle after DONE (IDLE accepts pending immediately).
//  frame_req in the same cycle as DONE: sets pending, i.e. exactly one follow-on frame.
//  init_end falls mid-frame: abort at once. Go to WAIT_INIT, drop busy, clear pending, own e=0.
//   No frame_done is issued. bus_sel clears next cycle. A partial DDRAM write is acceptable.
//  Async reset mid-frame: all registers go to reset values immediately. Pins revert to init_* passthrough.
// TESTING
//  1. init_end=0, toggle init_e/init_data -> lcd_e/lcd_data mirror them in the same cycle; busy=0; fb_addr stays 0.
//  2. init_end=1, 1-cycle frame_req, fb_data = addr+0x20 ->
//     nibbles 8,0, then 2,0 .. 2,F, then C,0, then 3,0 .. 3,F; rs pattern correct; frame_done at cycle 881.
//  3. Per nibble check: e high exactly 4 cycles, data stable from 2 cycles before rise to 2 cycles after fall; 8-cycle gaps.
//  4. frame_req pulsed 3 times during busy -> exactly one extra frame, starting the cycle after the first frame_done.
//  5. init_end dropped at cycle 300 -> busy=0 next cycle, no frame_done, pins follow init_* after bus_sel clears.
//     Re-raise init_end -> a new request works.
//  6. rst asserted mid-nibble with e=1 -> lcd_e/lcd_data follow init_*; after release, no output until init_end=1 and a new frame_req.

Source files
------------

// File: rtl/lcd_frame_writer.sv
// ============================================================================
// Module      : lcd_frame_writer
// Description : Takes over the 4-bit HD44780 bus once the CGRAM loader has
//               finished. Before that it passes the loader pins through.
//               Each frame request writes 2 rows x 16 character codes from
//               the frame buffer into DDRAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_frame_writer #(
  parameter int SETUP_CYC  = 2,
  parameter int E_HIGH_CYC = 4,
  parameter int HOLD_CYC   = 2,
  parameter int GAP_CYC    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_rs,
  input  logic       init_rw,
  input  logic       init_e,
  input  logic [3:0] init_data,
  input  logic       init_end,
  input  logic       frame_req,
  output logic [4:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic       busy,
  output logic       frame_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_data
);

  // Byte timing: two nibble windows followed by an idle gap
  localparam int C_NIB  = SETUP_CYC + E_HIGH_CYC + HOLD_CYC;
  localparam int C_BYTE = 2 * C_NIB + GAP_CYC;
  localparam int C_CW   = $clog2(C_BYTE);

  localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(C_BYTE - 1);
  localparam logic [C_CW-1:0] C_NIB_W    = C_CW'(C_NIB);
  localparam logic [C_CW-1:0] C_NIB2_W   = C_CW'(2 * C_NIB);
  localparam logic [C_CW-1:0] C_E_ON     = C_CW'(SETUP_CYC);
  localparam logic [C_CW-1:0] C_E_OFF    = C_CW'(SETUP_CYC + E_HIGH_CYC);

  localparam logic [2:0] S_WAIT_INIT = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_CMD       = 3'd2;
  localparam logic [2:0] S_FETCH     = 3'd3;
  localparam logic [2:0] S_CHAR      = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic            r_bus_sel;
  logic            r_pending;
  logic [C_CW-1:0] r_cnt;
  logic            r_fph;
  logic [4:0]      r_pos;
  logic [7:0]      r_char;
  logic [4:0]      r_fb_addr;

  logic            w_sending;
  logic            w_byte_end;
  logic            w_accept;
  logic [7:0]      w_byte;
  logic            w_hi;
  logic            w_in_nib;
  logic [C_CW-1:0] w_off;
  logic            w_own_rs;
  logic            w_own_e;
  logic [3:0]      w_own_data;

  assign w_sending  = (r_state == S_CMD) || (r_state == S_CHAR);
  assign w_byte_end = w_sending && (r_cnt == C_CNT_LAST);
  assign w_accept   = (r_state == S_IDLE) && (frame_req || r_pending);
  assign fb_addr    = r_fb_addr;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_WAIT_INIT;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a low init_end aborts from anywhere
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_INIT: if (init_end) w_state_nxt = S_IDLE;
      S_IDLE:      if (w_accept) w_state_nxt = S_CMD;
      S_CMD:       if (w_byte_end) w_state_nxt = S_FETCH;
      S_FETCH:     if (r_fph) w_state_nxt = S_CHAR;
      S_CHAR: begin
        if (w_byte_end) begin
          if (r_pos == 5'd31)      w_state_nxt = S_DONE;
          else if (r_pos == 5'd15) w_state_nxt = S_CMD;
          else                     w_state_nxt = S_FETCH;
        end
      end
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_WAIT_INIT;
    endcase
    if (!init_end && (r_state != S_WAIT_INIT)) w_state_nxt = S_WAIT_INIT;
  end

  // Output decode: byte selection, nibble phase and e strobe window
  always_comb begin
    w_byte     = (r_state == S_CHAR) ? r_char : {1'b1, r_pos[4], 6'd0};
    w_hi       = (r_cnt < C_NIB_W);
    w_in_nib   = (r_cnt < C_NIB2_W);
    w_off      = w_hi ? r_cnt : (r_cnt - C_NIB_W);
    w_own_rs   = 1'b0;
    w_own_e    = 1'b0;
    w_own_data = 4'd0;
    if (w_sending) begin
      w_own_rs   = (r_state == S_CHAR);
      w_own_e    = w_in_nib && (w_off >= C_E_ON) && (w_off < C_E_OFF);
      w_own_data = w_hi ? w_byte[7:4] : w_byte[3:0];
    end
    busy       = (r_state == S_CMD) || (r_state == S_FETCH) || (r_state == S_CHAR);
    frame_done = (r_state == S_DONE);
  end

  // Pin mux: loader passthrough until the bus has been handed over
  always_comb begin
    lcd_rs   = r_bus_sel ? w_own_rs   : init_rs;
    lcd_rw   = r_bus_sel ? 1'b0       : init_rw;
    lcd_e    = r_bus_sel ? w_own_e    : init_e;
    lcd_data = r_bus_sel ? w_own_data : init_data;
  end

  // Bus ownership follows the sampled init_end level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_bus_sel <= 1'b0;
    else     r_bus_sel <= init_end;
  end

  // One-deep request memory; requests arriving mid-frame or in DONE merge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     r_pending <= 1'b0;
    else if (!init_end || r_state == S_WAIT_INIT) r_pending <= 1'b0;
    else if (r_state == S_IDLE)                  r_pending <= 1'b0;
    else if (frame_req)                          r_pending <= 1'b1;
  end

  // Datapath: byte cycle counter, fetch phase, character pointer, address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_fph     <= 1'b0;
      r_pos     <= 5'd0;
      r_char    <= 8'd0;
      r_fb_addr <= 5'd0;
    end else begin
      if (w_sending && (r_cnt != C_CNT_LAST)) r_cnt <= r_cnt + 1'b1;
      else                                     r_cnt <= '0;
      r_fph <= (r_state == S_FETCH) ? ~r_fph : 1'b0;
      if ((r_state == S_FETCH) && r_fph) r_char <= fb_data;
      if (r_state == S_IDLE)                   r_pos <= 5'd0;
      else if ((r_state == S_CHAR) && w_byte_end) r_pos <= r_pos + 5'd1;
      // Address is presented in the first FETCH cycle
      if ((w_state_nxt == S_FETCH) && (r_state != S_FETCH))
        r_fb_addr <= (r_state == S_CHAR) ? (r_pos + 5'd1) : r_pos;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_frame_writer.sv
// ============================================================================
// Module      : tb_lcd_frame_writer
// Description : Scoreboard bench for lcd_frame_writer. Expected nibble
//               strobes and frame_done pulses are queued from a frame-level
//               model; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_frame_writer;

  localparam int SETUP  = 2;
  localparam int EHIGH  = 4;
  localparam int HOLD   = 2;
  localparam int GAP    = 8;
  localparam int BYTE_T = 2 * (SETUP + EHIGH + HOLD) + GAP;
  localparam int BIG    = 1000000;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_rs, init_rw, init_e, init_end, frame_req;
  logic [3:0] init_data;
  logic [4:0] fb_addr;
  logic [7:0] fb_data;
  logic       busy, frame_done, lcd_rs, lcd_rw, lcd_e;
  logic [3:0] lcd_data;

  lcd_frame_writer #(
    .SETUP_CYC(SETUP), .E_HIGH_CYC(EHIGH), .HOLD_CYC(HOLD), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .init_rs(init_rs), .init_rw(init_rw), .init_e(init_e),
    .init_data(init_data), .init_end(init_end),
    .frame_req(frame_req), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .frame_done(frame_done),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame buffer model: registered read
  logic [7:0] fb_mem [0:31];
  always @(posedge clk) fb_data <= fb_mem[fb_addr];

  typedef struct packed {
    logic       rs;
    logic [3:0] d;
    int         cyc;
  } nib_t;

  nib_t nib_q [$];
  int   done_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   own_bus = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Frame-level model: byte list, nibble strobe cycles, frame_done cycle.
  // t0 is the accept cycle; only strobes rising at or before 'limit' are kept.
  task automatic push_frame(input int t0, input int limit, input bit with_done);
    int t;
    int idx;
    logic [7:0] b;
    logic rs;
    nib_t n;
    t = t0 + 1;
    for (int j = 0; j < 34; j++) begin
      if (j == 0 || j == 17) begin
        b  = (j == 0) ? 8'h80 : 8'hC0;
        rs = 1'b0;
      end else begin
        idx = (j < 17) ? (j - 1) : (j - 2);
        b   = fb_mem[idx];
        rs  = 1'b1;
        t   = t + 2;
      end
      n.rs = rs; n.d = b[7:4]; n.cyc = t + SETUP;
      if (n.cyc <= limit) nib_q.push_back(n);
      n.rs = rs; n.d = b[3:0]; n.cyc = t + SETUP + EHIGH + HOLD + SETUP;
      if (n.cyc <= limit) nib_q.push_back(n);
      t = t + BYTE_T;
    end
    if (with_done) done_q.push_back(t);
  endtask

  // Monitor: frame_done scoreboard and nibble strobe / timing checks
  logic       m_prev_e;
  int         m_hi;
  int         m_hold;
  logic [4:0] m_h1, m_h2, m_ref, m_cur;
  nib_t       m_n;
  int         m_d;

  always @(negedge clk) begin
    if (frame_done) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame_done: unexpected pulse at cycle %0d, required none", cyc);
      end else begin
        m_d = done_q.pop_front();
        chk("frame_done_cycle", cyc, m_d);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
    if (!own_bus || rst) begin
      m_prev_e = 1'b0; m_hi = 0; m_hold = 0; m_h1 = '0; m_h2 = '0; m_ref = '0;
    end else begin
      m_cur = {lcd_rs, lcd_data};
      if (lcd_e && !m_prev_e) begin
        chk("setup_stable", {31'd0, (m_h1 == m_cur) && (m_h2 == m_cur)}, 32'd1);
        chk("rw_low", {31'd0, lcd_rw}, 32'd0);
        if (nib_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL nibble: unexpected strobe rs=%0d data=%0h at cycle %0d, required none",
                   lcd_rs, lcd_data, cyc);
        end else begin
          m_n = nib_q.pop_front();
          chk("nibble_cycle", cyc, m_n.cyc);
          chk("nibble_rs_data", {27'd0, m_cur}, {27'd0, m_n.rs, m_n.d});
        end
        m_ref = m_cur;
        m_hi  = 1;
      end else if (lcd_e) begin
        m_hi++;
        chk("data_while_e", {27'd0, m_cur}, {27'd0, m_ref});
      end else if (m_prev_e) begin
        chk("e_high_width", m_hi, EHIGH);
        chk("hold_data", {27'd0, m_cur}, {27'd0, m_ref});
        m_hold = HOLD - 1;
      end else if (m_hold > 0) begin
        chk("hold_data", {27'd0, m_cur}, {27'd0, m_ref});
        m_hold--;
      end
      m_h2 = m_h1; m_h1 = m_cur; m_prev_e = lcd_e;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 32; i++) fb_mem[i] = 8'($urandom_range(0, 6));
    fb_mem[$urandom_range(0, 31)] = 8'($urandom);
  endtask

  // Issue a one-cycle request; t0 returns the accept cycle
  task automatic do_frame(input int limit_off, input bit with_done, output int t0);
    t0 = cyc;
    push_frame(t0, t0 + limit_off, with_done);
    chk("busy_before_accept", {31'd0, busy}, 32'd0);
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  int t0, c1, c2, c3, r;

  initial begin
    for (int i = 0; i < 32; i++) fb_mem[i] = 8'd0;
    rst = 1'b1; init_rs = 1'b0; init_rw = 1'b0; init_e = 1'b1; init_data = 4'h5;
    init_end = 1'b0; frame_req = 1'b0;
    repeat (3) tick();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
    chk("reset_fb_addr", {27'd0, fb_addr}, 32'd0);
    chk("reset_pins_pass", {25'd0, lcd_rs, lcd_rw, lcd_e, lcd_data}, {25'd0, 3'b001, 4'h5});
    rst = 1'b0;
    tick();

    // Passthrough while the loader owns the bus
    for (int i = 0; i < 16; i++) begin
      init_rs = 1'($urandom); init_rw = 1'($urandom);
      init_e = 1'($urandom); init_data = 4'($urandom);
      #1;
      chk("passthrough", {25'd0, lcd_rs, lcd_rw, lcd_e, lcd_data},
          {25'd0, init_rs, init_rw, init_e, init_data});
      tick();
    end
    chk("pre_init_busy", {31'd0, busy}, 32'd0);
    chk("pre_init_fb_addr", {27'd0, fb_addr}, 32'd0);

    // Hand-over: bus_sel takes effect one cycle after init_end
    init_rs = 1'b0; init_e = 1'b0; init_data = 4'h0; init_rw = 1'b1; init_end = 1'b1;
    #1;
    chk("rw_before_handover", {31'd0, lcd_rw}, 32'd1);
    tick();
    chk("rw_after_handover", {31'd0, lcd_rw}, 32'd0);
    own_bus = 1'b1;
    repeat (3) tick();

    // Reference frame: code = addr + 0x20
    for (int i = 0; i < 32; i++) fb_mem[i] = 8'(i + 8'h20);
    do_frame(BIG, 1'b1, t0);
    wait_until(t0 + 885);
    chk("idle_after_frame", {31'd0, busy}, 32'd0);

    // Random frames with random idle gaps
    for (int k = 0; k < 2; k++) begin
      rand_mem();
      repeat ($urandom_range(0, 5)) tick();
      do_frame(BIG, 1'b1, t0);
      wait_until(t0 + 883);
    end

    // Three requests while busy merge into one follow-on frame
    rand_mem();
    do_frame(BIG, 1'b1, t0);
    push_frame(t0 + 882, BIG, 1'b1);
    c1 = t0 + 5 + $urandom_range(0, 279);
    c2 = c1 + 1 + $urandom_range(0, 279);
    c3 = c2 + 1 + $urandom_range(0, 279);
    wait_until(c1); frame_req = 1'b1; tick(); frame_req = 1'b0;
    wait_until(c2); frame_req = 1'b1; tick(); frame_req = 1'b0;
    wait_until(c3); frame_req = 1'b1; tick(); frame_req = 1'b0;
    wait_until(t0 + 882 + 890);

    // Request in the DONE cycle yields exactly one follow-on frame
    rand_mem();
    do_frame(BIG, 1'b1, t0);
    push_frame(t0 + 882, BIG, 1'b1);
    wait_until(t0 + 881);
    frame_req = 1'b1;
    #1;
    chk("done_with_req", {31'd0, frame_done}, 32'd1);
    tick();
    frame_req = 1'b0;
    chk("idle_between", {31'd0, busy}, 32'd0);
    tick();
    chk("follow_on_busy", {31'd0, busy}, 32'd1);
    wait_until(t0 + 882 + 890);

    // init_end dropped mid-frame
    rand_mem();
    do_frame(300, 1'b0, t0);
    wait_until(t0 + 300);
    init_end = 1'b0;
    tick();
    own_bus = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      init_rs = 1'($urandom); init_rw = 1'($urandom);
      init_e = 1'($urandom); init_data = 4'($urandom);
      #1;
      chk("abort_passthrough", {25'd0, lcd_rs, lcd_rw, lcd_e, lcd_data},
          {25'd0, init_rs, init_rw, init_e, init_data});
      tick();
    end
    init_rs = 1'b0; init_rw = 1'b0; init_e = 1'b0; init_data = 4'h0;
    wait_until(t0 + 900);
    chk("abort_still_idle", {31'd0, busy}, 32'd0);
    init_end = 1'b1;
    tick();
    own_bus = 1'b1;
    tick();
    rand_mem();
    do_frame(BIG, 1'b1, t0);
    wait_until(t0 + 885);

    // Asynchronous reset while e is high
    rand_mem();
    do_frame(SETUP + 2, 1'b0, t0);
    wait_until(t0 + 4);
    chk("e_high_before_rst", {31'd0, lcd_e}, 32'd1);
    init_data = 4'hA;
    rst = 1'b1;
    own_bus = 1'b0;
    #1;
    chk("rst_pins_pass", {26'd0, lcd_e, lcd_data}, {26'd0, 1'b0, 4'hA});
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fb_addr", {27'd0, fb_addr}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    init_data = 4'h0;
    tick();
    own_bus = 1'b1;
    r = cyc;
    wait_until(r + 60);
    chk("no_frame_after_rst", {31'd0, busy}, 32'd0);
    rand_mem();
    do_frame(BIG, 1'b1, t0);
    wait_until(t0 + 890);

    chk("nibbles_outstanding", nib_q.size(), 32'd0);
    chk("done_outstanding", done_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
